wb_scratch_slave: RTL and testbench



---
 rtl/wb_slave_pkg.sv | 27 ++
 rtl/wb_byte_ram.sv | 39 +++
 rtl/wb_scratch_slave.sv | 168 ++++++++++++++++
 tb/tb_wb_scratch_slave.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_slave_pkg
// Description : Shared register map, CTRL bit positions and FSM encoding
//               for the Wishbone scratch slave.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_slave_pkg;

  localparam logic [7:0] c_ADR_CTRL     = 8'h00;
  localparam logic [7:0] c_ADR_STATUS   = 8'h01;
  localparam logic [7:0] c_ADR_DOORBELL = 8'h02;

  localparam int c_CTRL_INT_EN = 0;
  localparam int c_CTRL_CLR    = 1;

  localparam int c_WAIT_W = 4;
  localparam int c_LANES  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/wb_byte_ram.sv
`default_nettype none
// ============================================================================
// Module      : wb_byte_ram
// Description : DEPTH x 32 synchronous RAM, per-byte write enables,
//               registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_byte_ram
  import wb_slave_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic               clk,
  input  logic [c_LANES-1:0] we,
  input  logic [AW-1:0]      addr,
  input  logic [31:0]        wdata,
  input  logic               re,
  output logic [31:0]        rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    for (int b = 0; b < c_LANES; b++) begin
      if (we[b]) begin
        r_mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) begin
      r_rdata <= r_mem[addr];
    end
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/wb_scratch_slave.sv
`default_nettype none
// ============================================================================
// Module      : wb_scratch_slave
// Description : Wishbone responder with CTRL/STATUS/DOORBELL registers, a
//               byte-writable scratch RAM and programmable ack wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_scratch_slave
  import wb_slave_pkg::*;
#(
  parameter int         DEPTH       = 16,
  parameter int         WAIT_STATES = 0,
  parameter logic [7:0] MEM_BASE    = 8'h10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbs_we_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_int_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_WAIT_W-1:0] c_WS = c_WAIT_W'(WAIT_STATES);

  state_t              r_state, w_next;
  logic [c_WAIT_W-1:0] r_cnt, w_cnt_nxt;
  logic                w_req, w_commit;

  logic        r_int_en, r_pending, r_int, r_rd_mem;
  logic [15:0] r_wr_count;
  logic [31:0] r_doorbell, r_reg_dat, w_reg_rdata, w_ram_q;

  logic [7:0]    w_adr, w_mem_off;
  logic          w_is_reg, w_in_mem, w_wr;
  logic [3:0]    w_ram_we;
  logic          w_ram_re;
  logic [AW-1:0] w_ram_addr;
  logic          w_unused;

  assign w_req = wbs_cyc_i & wbs_stb_i;

  // The commit strobe marks the single edge on which the FSM enters ACK.
  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    w_commit  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_cnt_nxt = c_WS;
          if (WAIT_STATES == 0) begin
            w_next   = ST_ACK;
            w_commit = 1'b1;
          end else begin
            w_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        w_cnt_nxt = r_cnt - 1'b1;
        if (!w_req) begin
          w_next = ST_IDLE;
        end else if (r_cnt <= 1) begin
          w_next   = ST_ACK;
          w_commit = 1'b1;
        end
      end
      ST_ACK: begin
        if (!w_req) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_adr      = wbs_adr_i[7:0];
  assign w_is_reg   = (w_adr <= c_ADR_DOORBELL);
  assign w_in_mem   = !w_is_reg && ({1'b0, w_adr} >= {1'b0, MEM_BASE})
                      && ({1'b0, w_adr} < ({1'b0, MEM_BASE} + 9'(DEPTH)));
  assign w_mem_off  = w_adr - MEM_BASE;
  assign w_ram_addr = w_mem_off[AW-1:0];
  assign w_wr       = w_commit & wbs_we_i & (|wbs_sel_i) & ~rst;
  assign w_ram_we   = {4{w_wr & w_in_mem}} & wbs_sel_i;
  assign w_ram_re   = w_commit & ~wbs_we_i & w_in_mem & ~rst;
  assign w_unused   = ^{wbs_adr_i[31:8], w_mem_off};

  always_comb begin
    w_reg_rdata = 32'h0;
    case (w_adr)
      c_ADR_CTRL:     w_reg_rdata = {31'h0, r_int_en};
      c_ADR_STATUS:   w_reg_rdata = {r_wr_count, 15'h0, r_pending};
      c_ADR_DOORBELL: w_reg_rdata = r_doorbell;
      default:        w_reg_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_int_en   <= 1'b0;
      r_pending  <= 1'b0;
      r_doorbell <= 32'h0;
      r_wr_count <= 16'h0;
      r_int      <= 1'b0;
      r_reg_dat  <= 32'h0;
      r_rd_mem   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_int   <= r_pending & r_int_en;
      if (w_commit) begin
        r_rd_mem  <= ~wbs_we_i & w_in_mem;
        r_reg_dat <= wbs_we_i ? 32'h0 : w_reg_rdata;
      end
      if (w_wr) begin
        case (w_adr)
          c_ADR_CTRL: begin
            if (wbs_sel_i[0]) begin
              r_int_en <= wbs_dat_i[c_CTRL_INT_EN];
              if (wbs_dat_i[c_CTRL_CLR]) begin
                r_pending <= 1'b0;
              end
            end
          end
          c_ADR_DOORBELL: begin
            for (int b = 0; b < c_LANES; b++) begin
              if (wbs_sel_i[b]) begin
                r_doorbell[8*b +: 8] <= wbs_dat_i[8*b +: 8];
              end
            end
            r_pending <= 1'b1;
          end
          default: begin
            if (w_in_mem) begin
              r_wr_count <= r_wr_count + 16'h1;
            end
          end
        endcase
      end
    end
  end

  wb_byte_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (w_ram_we),
    .addr  (w_ram_addr),
    .wdata (wbs_dat_i),
    .re    (w_ram_re),
    .rdata (w_ram_q)
  );

  assign wbs_ack_o = (r_state == ST_ACK);
  assign wbs_dat_o = r_rd_mem ? w_ram_q : r_reg_dat;
  assign wbs_int_o = r_int;

endmodule
`default_nettype wire

// File: tb/tb_wb_scratch_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_scratch_slave
// Description : Directed self-checking bench; dut0 has no wait states,
//               dut1 has three.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_scratch_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        wbs_we, wbs_stb, cyc0, cyc1;
  logic [3:0]  wbs_sel;
  logic [31:0] wbs_adr, wbs_dat;
  logic [31:0] dat0, dat1;
  logic        ack0, ack1, int0, int1;

  int checks = 0;
  int errors = 0;
  logic int_at_ack;

  always #5 clk = ~clk;

  wb_scratch_slave #(.DEPTH(16), .WAIT_STATES(0), .MEM_BASE(8'h10)) dut0 (
    .clk(clk), .rst(rst), .wbs_we_i(wbs_we), .wbs_cyc_i(cyc0), .wbs_stb_i(wbs_stb),
    .wbs_sel_i(wbs_sel), .wbs_adr_i(wbs_adr), .wbs_dat_i(wbs_dat),
    .wbs_dat_o(dat0), .wbs_ack_o(ack0), .wbs_int_o(int0)
  );

  wb_scratch_slave #(.DEPTH(16), .WAIT_STATES(3), .MEM_BASE(8'h10)) dut1 (
    .clk(clk), .rst(rst), .wbs_we_i(wbs_we), .wbs_cyc_i(cyc1), .wbs_stb_i(wbs_stb),
    .wbs_sel_i(wbs_sel), .wbs_adr_i(wbs_adr), .wbs_dat_i(wbs_dat),
    .wbs_dat_o(dat1), .wbs_ack_o(ack1), .wbs_int_o(int1)
  );

  function automatic logic ack_of(input int d);
    return (d == 0) ? ack0 : ack1;
  endfunction

  // One classic Wishbone transfer; lat counts edges from first sampled stb to ack.
  task automatic xfer(input int d, input logic w, input logic [7:0] a,
                      input logic [31:0] wd, input logic [3:0] s,
                      output logic [31:0] rd, output int lat);
    @(negedge clk);
    wbs_we = w; wbs_adr = {24'h0, a}; wbs_dat = wd; wbs_sel = s; wbs_stb = 1'b1;
    if (d == 0) cyc0 = 1'b1; else cyc1 = 1'b1;
    lat = 0;
    rd  = 32'h0;
    int_at_ack = 1'b0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (ack_of(d)) break;
    end
    if (!ack_of(d)) begin
      checks++; errors++;
      $display("FAIL ack_timeout dut%0d adr=%h: no ack within 40 cycles", d, a);
      lat = -1;
    end else begin
      rd = (d == 0) ? dat0 : dat1;
      int_at_ack = (d == 0) ? int0 : int1;
    end
    cyc0 = 1'b0; cyc1 = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc0 = 1'b0; cyc1 = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
    wbs_sel = 4'h0; wbs_adr = 32'h0; wbs_dat = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL reset_ack0 got=%b exp=0", ack0); end
    checks++; if (dat0 !== 32'h0) begin errors++; $display("FAIL reset_dat0 got=%h exp=0", dat0); end
    checks++; if (int0 !== 1'b0) begin errors++; $display("FAIL reset_int0 got=%b exp=0", int0); end
    checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL reset_ack1 got=%b exp=0", ack1); end
    checks++; if (dat1 !== 32'h0) begin errors++; $display("FAIL reset_dat1 got=%h exp=0", dat1); end
    checks++; if (int1 !== 1'b0) begin errors++; $display("FAIL reset_int1 got=%b exp=0", int1); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] rd; int lat;
    xfer(0, 1'b1, 8'h10, 32'hA5A5_1234, 4'hF, rd, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL ws0_write_lat got=%0d exp=1", lat); end
    xfer(0, 1'b0, 8'h10, 32'h0, 4'hF, rd, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL ws0_read_lat got=%0d exp=1", lat); end
    checks++; if (rd !== 32'hA5A5_1234) begin errors++; $display("FAIL ram_read got=%h exp=a5a51234", rd); end
    xfer(0, 1'b0, 8'h01, 32'h0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h0001_0000) begin errors++; $display("FAIL status_count1 got=%h exp=00010000", rd); end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; int lat;
    xfer(1, 1'b0, 8'h01, 32'h0, 4'hF, rd, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL ws3_lat got=%0d exp=4", lat); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ws3_status got=%h exp=0", rd); end
    // abort after two cycles in WAIT
    @(negedge clk);
    wbs_we = 1'b0; wbs_adr = 32'h1; wbs_sel = 4'hF; wbs_stb = 1'b1; cyc1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); @(negedge clk);
      checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL abort_ack cyc%0d got=%b exp=0", i, ack1); end
    end
    cyc1 = 1'b0; wbs_stb = 1'b0;
    repeat (4) begin
      @(posedge clk); @(negedge clk);
      checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL abort_after got=%b exp=0", ack1); end
    end
    xfer(1, 1'b0, 8'h00, 32'h0, 4'hF, rd, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL abort_idle_lat got=%0d exp=4", lat); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; int lat;
    xfer(0, 1'b1, 8'h11, 32'hFFFF_FFFF, 4'hF, rd, lat);
    xfer(0, 1'b1, 8'h11, 32'h0000_0000, 4'b0101, rd, lat);
    xfer(0, 1'b0, 8'h11, 32'h0, 4'hF, rd, lat);
    checks++; if (rd !== 32'hFF00_FF00) begin errors++; $display("FAIL byte_lanes got=%h exp=ff00ff00", rd); end
  endtask

  task automatic test_interrupt();
    logic [31:0] rd; int lat;
    xfer(0, 1'b1, 8'h00, 32'h1, 4'hF, rd, lat);
    xfer(0, 1'b1, 8'h02, 32'h0000_CAFE, 4'hF, rd, lat);
    checks++; if (int_at_ack !== 1'b0) begin errors++; $display("FAIL int_early got=%b exp=0", int_at_ack); end
    checks++; if (int0 !== 1'b1) begin errors++; $display("FAIL int_set got=%b exp=1", int0); end
    xfer(0, 1'b0, 8'h01, 32'h0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h0003_0001) begin errors++; $display("FAIL status_pending got=%h exp=00030001", rd); end
    xfer(0, 1'b1, 8'h00, 32'h3, 4'hF, rd, lat);
    checks++; if (int0 !== 1'b0) begin errors++; $display("FAIL int_clear got=%b exp=0", int0); end
    xfer(0, 1'b0, 8'h00, 32'h0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL ctrl_read got=%h exp=1", rd); end
    xfer(0, 1'b1, 8'h02, 32'hFFFF_FFFF, 4'h0, rd, lat);
    checks++; if (int0 !== 1'b0) begin errors++; $display("FAIL sel0_doorbell_int got=%b exp=0", int0); end
    xfer(0, 1'b0, 8'h01, 32'h0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h0003_0000) begin errors++; $display("FAIL status_cleared got=%h exp=00030000", rd); end
    xfer(0, 1'b0, 8'h02, 32'h0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h0000_CAFE) begin errors++; $display("FAIL doorbell_read got=%h exp=0000cafe", rd); end
  endtask

  task automatic test_unmapped();
    logic [31:0] rd; int lat;
    logic [7:0] adrs [2];
    adrs[0] = 8'h05;
    adrs[1] = 8'h20;
    for (int i = 0; i < 2; i++) begin
      xfer(0, 1'b1, adrs[i], 32'hFFFF_FFFF, 4'hF, rd, lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL unmapped_wr_lat adr=%h got=%0d exp=1", adrs[i], lat); end
      xfer(0, 1'b0, adrs[i], 32'h0, 4'hF, rd, lat);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL unmapped_rd adr=%h got=%h exp=0", adrs[i], rd); end
    end
    xfer(0, 1'b1, 8'h10, 32'h0, 4'h0, rd, lat);
    xfer(0, 1'b0, 8'h10, 32'h0, 4'hF, rd, lat);
    checks++; if (rd !== 32'hA5A5_1234) begin errors++; $display("FAIL sel0_ram got=%h exp=a5a51234", rd); end
    xfer(0, 1'b0, 8'h01, 32'h0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h0003_0000) begin errors++; $display("FAIL unmapped_count got=%h exp=00030000", rd); end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd; int lat;
    xfer(1, 1'b1, 8'h10, 32'h1111_1111, 4'hF, rd, lat);
    @(negedge clk);
    wbs_we = 1'b1; wbs_adr = 32'h10; wbs_dat = 32'h2222_2222; wbs_sel = 4'hF;
    wbs_stb = 1'b1; cyc1 = 1'b1;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL rst_wait_ack cyc%0d got=%b exp=0", i, ack1); end
    end
    cyc1 = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    xfer(1, 1'b0, 8'h10, 32'h0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h1111_1111) begin errors++; $display("FAIL rst_no_write got=%h exp=11111111", rd); end
    xfer(1, 1'b0, 8'h01, 32'h0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_status got=%h exp=0", rd); end
  endtask

  task automatic test_count_wrap();
    logic [31:0] rd; int lat; int acks;
    acks = 0;
    @(negedge clk);
    wbs_we = 1'b1; wbs_sel = 4'hF; wbs_adr = 32'h12; wbs_dat = 32'h5A5A_5A5A;
    for (int i = 0; i < 65535; i++) begin
      cyc0 = 1'b1; wbs_stb = 1'b1;
      @(posedge clk); @(negedge clk);
      if (ack0) acks++;
      cyc0 = 1'b0; wbs_stb = 1'b0;
      @(posedge clk); @(negedge clk);
    end
    wbs_we = 1'b0;
    checks++; if (acks !== 65535) begin errors++; $display("FAIL burst_acks got=%0d exp=65535", acks); end
    xfer(0, 1'b0, 8'h01, 32'h0, 4'hF, rd, lat);
    checks++; if (rd !== 32'hFFFF_0000) begin errors++; $display("FAIL count_max got=%h exp=ffff0000", rd); end
    xfer(0, 1'b1, 8'h12, 32'h0, 4'hF, rd, lat);
    xfer(0, 1'b0, 8'h01, 32'h0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL count_wrap got=%h exp=0", rd); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_states();
    test_byte_lanes();
    test_interrupt();
    test_unmapped();
    test_reset_in_wait();
    test_count_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
